// File: rtl/sweep_peak_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sweep_peak_tracker                                         |
// | Description : Serpentine two-axis raster sweep with ADC req/valid        |
// |               sampling, peak tracking and park-on-peak.                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sweep_peak_tracker #(
    parameter int POS_W   = 32,
    parameter int V_W     = 12,
    parameter int POS_MIN = 0,
    parameter int POS_MAX = 1000,
    parameter int STEP    = 50,
    parameter int SETTLE  = 16,
    parameter int HYST    = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             ABORT,
    input  logic             MODE,
    output logic             SAMPLE_REQ,
    input  logic             SAMPLE_VALID,
    input  logic [V_W-1:0]   SAMPLE,
    output logic [POS_W-1:0] POS_H,
    output logic [POS_W-1:0] POS_V,
    output logic [V_W-1:0]   MAX_V,
    output logic [POS_W-1:0] MAX_POS_H,
    output logic [POS_W-1:0] MAX_POS_V,
    output logic             BUSY,
    output logic             DONE,
    output logic [2:0]       STATE
);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_SETTLE  = 3'd1;
    localparam logic [2:0] c_ST_REQ     = 3'd2;
    localparam logic [2:0] c_ST_WAIT    = 3'd3;
    localparam logic [2:0] c_ST_EVAL    = 3'd4;
    localparam logic [2:0] c_ST_PARK    = 3'd5;
    localparam logic [2:0] c_ST_PSETTLE = 3'd6;

    localparam int                 c_CNT_W    = $clog2(SETTLE + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(SETTLE);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    // One extra bit keeps the clamping arithmetic free of wrap-around.
    localparam logic [POS_W:0]   c_MIN_X  = (POS_W+1)'(POS_MIN);
    localparam logic [POS_W:0]   c_MAX_X  = (POS_W+1)'(POS_MAX);
    localparam logic [POS_W:0]   c_STEP_X = (POS_W+1)'(STEP);
    localparam logic [POS_W-1:0] c_MIN    = POS_W'(POS_MIN);
    localparam logic [POS_W-1:0] c_MAX    = POS_W'(POS_MAX);
    localparam logic [V_W:0]     c_HYST_X = (V_W+1)'(HYST);

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [POS_W-1:0]   r_pos_h;
    logic [POS_W-1:0]   r_pos_v;
    logic [V_W-1:0]     r_max_v;
    logic [POS_W-1:0]   r_max_pos_h;
    logic [POS_W-1:0]   r_max_pos_v;
    logic [V_W-1:0]     r_sample;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_first;
    logic               r_dir_up;
    logic               r_mode;

    logic [POS_W:0]     w_up_sum;
    logic [POS_W:0]     w_dn_dif;
    logic [POS_W:0]     w_v_sum;
    logic [POS_W-1:0]   w_h_up;
    logic [POS_W-1:0]   w_h_dn;
    logic [POS_W-1:0]   w_v_next;
    logic               w_row_end;
    logic               w_new_peak;
    logic               w_cnt_last;

    always_comb begin
        w_up_sum   = {1'b0, r_pos_h} + c_STEP_X;
        w_dn_dif   = {1'b0, r_pos_h} - c_STEP_X;
        w_v_sum    = {1'b0, r_pos_v} + c_STEP_X;
        w_h_up     = (w_up_sum > c_MAX_X) ? c_MAX : w_up_sum[POS_W-1:0];
        w_h_dn     = (w_dn_dif[POS_W] || (w_dn_dif < c_MIN_X)) ? c_MIN : w_dn_dif[POS_W-1:0];
        w_v_next   = (w_v_sum > c_MAX_X) ? c_MAX : w_v_sum[POS_W-1:0];
        w_row_end  = r_dir_up ? (r_pos_h == c_MAX) : (r_pos_h == c_MIN);
        w_new_peak = r_first || ({1'b0, r_sample} > ({1'b0, r_max_v} + c_HYST_X));
        w_cnt_last = (r_cnt <= c_CNT_ONE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (START) w_state_nxt = c_ST_SETTLE;
            end
            c_ST_SETTLE: begin
                if (ABORT)           w_state_nxt = c_ST_PARK;
                else if (w_cnt_last) w_state_nxt = c_ST_REQ;
            end
            c_ST_REQ: begin
                w_state_nxt = ABORT ? c_ST_PARK : c_ST_WAIT;
            end
            c_ST_WAIT: begin
                if (ABORT)             w_state_nxt = c_ST_PARK;
                else if (SAMPLE_VALID) w_state_nxt = c_ST_EVAL;
            end
            c_ST_EVAL: begin
                if (ABORT)                          w_state_nxt = c_ST_PARK;
                else if (!w_row_end)                w_state_nxt = c_ST_SETTLE;
                else if (!r_mode || r_pos_v == c_MAX) w_state_nxt = c_ST_PARK;
                else                                w_state_nxt = c_ST_SETTLE;
            end
            c_ST_PARK: begin
                w_state_nxt = c_ST_PSETTLE;
            end
            c_ST_PSETTLE: begin
                if (w_cnt_last) w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pos_h     <= c_MIN;
            r_pos_v     <= c_MIN;
            r_max_v     <= '0;
            r_max_pos_h <= c_MIN;
            r_max_pos_v <= c_MIN;
            r_sample    <= '0;
            r_cnt       <= '0;
            r_first     <= 1'b0;
            r_dir_up    <= 1'b1;
            r_mode      <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (START) begin
                        r_pos_h     <= c_MIN;
                        r_pos_v     <= c_MIN;
                        r_max_v     <= '0;
                        r_max_pos_h <= c_MIN;
                        r_max_pos_v <= c_MIN;
                        r_first     <= 1'b1;
                        r_dir_up    <= 1'b1;
                        r_mode      <= MODE;
                        r_cnt       <= c_CNT_LOAD;
                    end
                end
                c_ST_SETTLE, c_ST_PSETTLE: begin
                    r_cnt <= r_cnt - c_CNT_ONE;
                end
                c_ST_WAIT: begin
                    if (SAMPLE_VALID) r_sample <= SAMPLE;
                end
                c_ST_EVAL: begin
                    // The peak update happens even when ABORT cuts the sweep short.
                    if (w_new_peak) begin
                        r_max_v     <= r_sample;
                        r_max_pos_h <= r_pos_h;
                        r_max_pos_v <= r_pos_v;
                        r_first     <= 1'b0;
                    end
                    r_cnt <= c_CNT_LOAD;
                    if (!ABORT) begin
                        if (!w_row_end) begin
                            r_pos_h <= r_dir_up ? w_h_up : w_h_dn;
                        end else if (r_mode && r_pos_v != c_MAX) begin
                            r_pos_v  <= w_v_next;
                            r_dir_up <= ~r_dir_up;
                        end
                    end
                end
                c_ST_PARK: begin
                    r_pos_h <= r_max_pos_h;
                    r_pos_v <= r_max_pos_v;
                    r_cnt   <= c_CNT_LOAD;
                end
                default: ;
            endcase
        end
    end

    assign SAMPLE_REQ = (r_state == c_ST_REQ);
    assign BUSY       = (r_state != c_ST_IDLE);
    assign DONE       = (r_state == c_ST_PSETTLE) && w_cnt_last && !RST;
    assign STATE      = r_state;
    assign POS_H      = r_pos_h;
    assign POS_V      = r_pos_v;
    assign MAX_V      = r_max_v;
    assign MAX_POS_H  = r_max_pos_h;
    assign MAX_POS_V  = r_max_pos_v;

endmodule
`default_nettype wire

// File: tb/tb_sweep_peak_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_sweep_peak_tracker                                      |
// | Description : Directed self-checking bench for sweep_peak_tracker.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_sweep_peak_tracker;

    // Instance 0: base grid 0..4 step 2; 1: HYST=5; 2: POS_MAX=5 (clamped row).
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start    [3];
    logic        abort    [3];
    logic        mode     [3];
    logic        valid    [3];
    logic [11:0] smp_in   [3];
    logic        req      [3];
    logic [31:0] pos_h    [3];
    logic [31:0] pos_v    [3];
    logic [11:0] max_v    [3];
    logic [31:0] max_h    [3];
    logic [31:0] max_pv   [3];
    logic        busy     [3];
    logic        done     [3];
    logic [2:0]  state    [3];

    int n_checks = 0;
    int n_errors = 0;
    int exp_h[$];
    int exp_v[$];
    int smp[$];
    int exp_pk[$];

    always #5 CLK = ~CLK;

    sweep_peak_tracker #(.POS_W(32), .V_W(12), .POS_MIN(0), .POS_MAX(4), .STEP(2), .SETTLE(2), .HYST(0)) u_dut0 (
        .CLK(CLK), .RST(RST), .START(start[0]), .ABORT(abort[0]), .MODE(mode[0]),
        .SAMPLE_REQ(req[0]), .SAMPLE_VALID(valid[0]), .SAMPLE(smp_in[0]),
        .POS_H(pos_h[0]), .POS_V(pos_v[0]), .MAX_V(max_v[0]), .MAX_POS_H(max_h[0]),
        .MAX_POS_V(max_pv[0]), .BUSY(busy[0]), .DONE(done[0]), .STATE(state[0]));

    sweep_peak_tracker #(.POS_W(32), .V_W(12), .POS_MIN(0), .POS_MAX(4), .STEP(2), .SETTLE(2), .HYST(5)) u_dut1 (
        .CLK(CLK), .RST(RST), .START(start[1]), .ABORT(abort[1]), .MODE(mode[1]),
        .SAMPLE_REQ(req[1]), .SAMPLE_VALID(valid[1]), .SAMPLE(smp_in[1]),
        .POS_H(pos_h[1]), .POS_V(pos_v[1]), .MAX_V(max_v[1]), .MAX_POS_H(max_h[1]),
        .MAX_POS_V(max_pv[1]), .BUSY(busy[1]), .DONE(done[1]), .STATE(state[1]));

    sweep_peak_tracker #(.POS_W(32), .V_W(12), .POS_MIN(0), .POS_MAX(5), .STEP(2), .SETTLE(2), .HYST(0)) u_dut2 (
        .CLK(CLK), .RST(RST), .START(start[2]), .ABORT(abort[2]), .MODE(mode[2]),
        .SAMPLE_REQ(req[2]), .SAMPLE_VALID(valid[2]), .SAMPLE(smp_in[2]),
        .POS_H(pos_h[2]), .POS_V(pos_v[2]), .MAX_V(max_v[2]), .MAX_POS_H(max_h[2]),
        .MAX_POS_V(max_pv[2]), .BUSY(busy[2]), .DONE(done[2]), .STATE(state[2]));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_start(input int d, input logic m);
        mode[d]  = m;
        start[d] = 1'b1;
        tick();
        start[d] = 1'b0;
        chk("busy_after_start", 64'(busy[d]), 64'd1);
    endtask

    // Answer each request with the next sample, checking the setpoints and
    // the running peak presented while the request is up.
    task automatic serve(input int d);
        for (int i = 0; i < smp.size(); i++) begin
            bit seen = 0;
            for (int k = 0; k < 100; k++) begin
                if (req[d]) begin seen = 1; break; end
                tick();
            end
            chk($sformatf("req_seen[%0d]", i), 64'(seen), 64'd1);
            if (!seen) return;
            chk($sformatf("req_pos_h[%0d]", i), 64'(pos_h[d]), 64'(exp_h[i]));
            chk($sformatf("req_pos_v[%0d]", i), 64'(pos_v[d]), 64'(exp_v[i]));
            chk($sformatf("req_peak[%0d]", i),  64'(max_v[d]), 64'(exp_pk[i]));
            tick();
            chk("req_one_cycle", 64'(req[d]), 64'd0);
            valid[d]  = 1'b1;
            smp_in[d] = 12'(smp[i]);
            tick();
            valid[d]  = 1'b0;
            smp_in[d] = 12'hABC;
        end
    endtask

    task automatic expect_park(input int d, input int pk, input int ph, input int pv);
        bit seen = 0;
        for (int k = 0; k < 100; k++) begin
            if (done[d]) begin seen = 1; break; end
            tick();
        end
        chk("done_seen", 64'(seen), 64'd1);
        chk("park_max_v", 64'(max_v[d]), 64'(pk));
        chk("park_max_h", 64'(max_h[d]), 64'(ph));
        chk("park_max_pv", 64'(max_pv[d]), 64'(pv));
        chk("park_pos_h", 64'(pos_h[d]), 64'(ph));
        chk("park_pos_v", 64'(pos_v[d]), 64'(pv));
        tick();
        chk("done_one_cycle", 64'(done[d]), 64'd0);
        chk("busy_after_done", 64'(busy[d]), 64'd0);
        chk("state_idle", 64'(state[d]), 64'd0);
        chk("pos_hold_h", 64'(pos_h[d]), 64'(ph));
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < 3; i++) begin
            start[i] = 0; abort[i] = 0; mode[i] = 0; valid[i] = 0; smp_in[i] = '0;
        end
        tick(); tick();
        RST = 1'b0;
        tick();

        chk("rst_state", 64'(state[0]), 64'd0);
        chk("rst_pos_h", 64'(pos_h[0]), 64'd0);
        chk("rst_pos_v", 64'(pos_v[0]), 64'd0);
        chk("rst_max_v", 64'(max_v[0]), 64'd0);
        chk("rst_busy", 64'(busy[0]), 64'd0);
        chk("rst_done", 64'(done[0]), 64'd0);
        chk("rst_req", 64'(req[0]), 64'd0);

        // Horizontal-only sweep
        exp_h = '{0, 2, 4}; exp_v = '{0, 0, 0}; smp = '{10, 30, 20}; exp_pk = '{0, 10, 30};
        do_start(0, 1'b0);
        serve(0);
        expect_park(0, 30, 2, 0);

        // Full raster, with a START pulse mid-sweep that must be ignored
        exp_h  = '{0, 2, 4, 4, 2, 0, 0, 2, 4};
        exp_v  = '{0, 0, 0, 2, 2, 2, 4, 4, 4};
        smp    = '{1, 2, 3, 4, 9, 5, 6, 7, 8};
        exp_pk = '{0, 1, 2, 3, 4, 9, 9, 9, 9};
        do_start(0, 1'b1);
        start[0] = 1'b1; tick(); start[0] = 1'b0;
        serve(0);
        expect_park(0, 9, 2, 2);

        // Hysteresis band
        exp_h = '{0, 2, 4}; exp_v = '{0, 0, 0}; smp = '{100, 104, 106}; exp_pk = '{0, 100, 100};
        do_start(1, 1'b0);
        serve(1);
        expect_park(1, 106, 4, 0);

        // Clamped last point and a tie
        exp_h = '{0, 2, 4, 5}; exp_v = '{0, 0, 0, 0}; smp = '{5, 7, 7, 1}; exp_pk = '{0, 5, 7, 7};
        do_start(2, 1'b0);
        serve(2);
        expect_park(2, 7, 2, 0);

        // ABORT while waiting for the second sample
        exp_h = '{0}; exp_v = '{0}; smp = '{50}; exp_pk = '{0};
        do_start(0, 1'b0);
        serve(0);
        seen = 0;
        for (int k = 0; k < 100; k++) begin
            if (req[0]) begin seen = 1; break; end
            tick();
        end
        chk("abort_req2_seen", 64'(seen), 64'd1);
        chk("abort_req2_h", 64'(pos_h[0]), 64'd2);
        tick();
        chk("abort_in_wait", 64'(state[0]), 64'd3);
        abort[0] = 1'b1;
        tick();
        abort[0] = 1'b0;
        chk("abort_to_park", 64'(state[0]), 64'd5);
        expect_park(0, 50, 0, 0);

        // Reset during SETTLE of row 1
        exp_h = '{0, 2, 4}; exp_v = '{0, 0, 0}; smp = '{1, 2, 3}; exp_pk = '{0, 1, 2};
        do_start(0, 1'b1);
        serve(0);
        seen = 0;
        for (int k = 0; k < 100; k++) begin
            if (state[0] == 3'd1 && pos_v[0] == 32'd2) begin seen = 1; break; end
            tick();
        end
        chk("row1_settle_seen", 64'(seen), 64'd1);
        RST = 1'b1;
        chk("no_done_in_rst", 64'(done[0]), 64'd0);
        tick();
        RST = 1'b0;
        chk("mid_rst_state", 64'(state[0]), 64'd0);
        chk("mid_rst_pos_h", 64'(pos_h[0]), 64'd0);
        chk("mid_rst_pos_v", 64'(pos_v[0]), 64'd0);
        chk("mid_rst_max_v", 64'(max_v[0]), 64'd0);
        chk("mid_rst_done", 64'(done[0]), 64'd0);
        tick();
        chk("post_rst_idle", 64'(busy[0]), 64'd0);

        exp_h = '{0, 2, 4}; exp_v = '{0, 0, 0}; smp = '{10, 30, 20}; exp_pk = '{0, 10, 30};
        do_start(0, 1'b0);
        serve(0);
        expect_park(0, 30, 2, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
